// File: rtl/game_flow_fsm.sv
// Page and turn controller for the game.
// Tracks the current page and the menu/action cursors, runs the ATTACK and
// DODGE turn timers, and turns raw key codes into single press events.
// Every output comes straight from a register.
module game_flow_fsm #(
  parameter int unsigned MENU_ITEMS    = 3,
  parameter int unsigned ACTION_ITEMS  = 4,
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned TIMER_W       = 16,
  parameter int unsigned ATTACK_CYCLES = 500,
  parameter int unsigned DODGE_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         keyboard_i,
  input  logic               setup_done_i,
  input  logic               is_death_i,
  output logic [3:0]         page_o,
  output logic               page_changed_o,
  output logic [SEL_W-1:0]   menu_sel_o,
  output logic [SEL_W-1:0]   action_sel_o,
  output logic               action_pick_o,
  output logic [TIMER_W-1:0] timer_o,
  output logic               strike_valid_o,
  output logic [TIMER_W-1:0] strike_pos_o,
  output logic [3:0]         player_instruction_o,
  output logic               is_move_o
);

  typedef enum logic [3:0] {
    StNull     = 4'b0000,
    StMenu     = 4'b0001,
    StGameover = 4'b0010,
    StStart    = 4'b1000,
    StDodge    = 4'b1001,
    StAttack   = 4'b1010,
    StAction   = 4'b1011
  } page_e;

  localparam logic [3:0] KeyIdle  = 4'd0;
  localparam logic [3:0] KeyUp    = 4'd1;
  localparam logic [3:0] KeyLeft  = 4'd2;
  localparam logic [3:0] KeyDown  = 4'd3;
  localparam logic [3:0] KeyRight = 4'd4;
  localparam logic [3:0] KeyEnter = 4'd5;

  localparam logic [SEL_W-1:0]   MenuLast   = SEL_W'(MENU_ITEMS - 1);
  localparam logic [SEL_W-1:0]   ActionLast = SEL_W'(ACTION_ITEMS - 1);
  localparam logic [TIMER_W-1:0] AttackLoad = TIMER_W'(ATTACK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DodgeLoad  = TIMER_W'(DODGE_CYCLES - 1);

  page_e              page_q, page_d;
  logic               page_changed_q, page_changed_d;
  logic [SEL_W-1:0]   menu_sel_q, menu_sel_d;
  logic [SEL_W-1:0]   action_sel_q, action_sel_d;
  logic               action_pick_q, action_pick_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               strike_valid_q, strike_valid_d;
  logic [TIMER_W-1:0] strike_pos_q, strike_pos_d;
  logic [3:0]         pinstr_q, pinstr_d;
  logic               is_move_q, is_move_d;
  logic [3:0]         key_prev_q;

  logic [3:0] key_c;
  logic       press;
  logic       up_ev, down_ev, left_ev, right_ev, enter_ev;

  // Key decode: unknown codes count as IDLE; an event is an IDLE -> key edge.
  always_comb begin
    key_c    = (keyboard_i > KeyEnter) ? KeyIdle : keyboard_i;
    press    = (key_c != KeyIdle) && (key_prev_q == KeyIdle);
    up_ev    = press && (key_c == KeyUp);
    down_ev  = press && (key_c == KeyDown);
    left_ev  = press && (key_c == KeyLeft);
    right_ev = press && (key_c == KeyRight);
    enter_ev = press && (key_c == KeyEnter);
  end

  // Next-state logic for the page, cursors, timer and registered outputs.
  always_comb begin
    page_d         = page_q;
    menu_sel_d     = menu_sel_q;
    action_sel_d   = action_sel_q;
    action_pick_d  = 1'b0;
    timer_d        = timer_q;
    strike_valid_d = 1'b0;
    strike_pos_d   = strike_pos_q;
    pinstr_d       = KeyIdle;

    case (page_q)
      StNull: page_d = StMenu;
      StMenu: begin
        if (up_ev) begin
          menu_sel_d = (menu_sel_q == '0) ? MenuLast : menu_sel_q - 1'b1;
        end else if (down_ev) begin
          menu_sel_d = (menu_sel_q == MenuLast) ? '0 : menu_sel_q + 1'b1;
        end else if (enter_ev && (menu_sel_q == '0)) begin
          page_d = StStart;
        end
      end
      StStart: begin
        if (setup_done_i) begin
          page_d       = StAction;
          action_sel_d = '0;
        end
      end
      StAction: begin
        if (is_death_i) begin
          page_d  = StGameover;
          timer_d = '0;
        end else if (left_ev) begin
          action_sel_d = (action_sel_q == '0) ? ActionLast : action_sel_q - 1'b1;
        end else if (right_ev) begin
          action_sel_d = (action_sel_q == ActionLast) ? '0 : action_sel_q + 1'b1;
        end else if (enter_ev) begin
          if (action_sel_q == '0) begin
            page_d  = StAttack;
            timer_d = AttackLoad;
          end else begin
            action_pick_d = 1'b1;
            page_d        = StDodge;
            timer_d       = DodgeLoad;
          end
        end
      end
      StAttack: begin
        if (is_death_i) begin
          page_d  = StGameover;
          timer_d = '0;
        end else if (timer_q == '0) begin
          // Expiry wins over a same-cycle ENTER: that counts as a miss.
          strike_valid_d = 1'b1;
          strike_pos_d   = '0;
          page_d         = StDodge;
          timer_d        = DodgeLoad;
        end else if (enter_ev) begin
          strike_valid_d = 1'b1;
          strike_pos_d   = timer_q;
          page_d         = StDodge;
          timer_d        = DodgeLoad;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDodge: begin
        if (is_death_i) begin
          page_d  = StGameover;
          timer_d = '0;
        end else if (timer_q == '0) begin
          page_d = StAction;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StGameover: begin
        if (enter_ev) begin
          page_d       = StMenu;
          menu_sel_d   = '0;
          action_sel_d = '0;
        end
      end
      default: page_d = StNull;
    endcase

    // Motion only while staying in DODGE, so it drops to IDLE as the page leaves.
    if ((page_q == StDodge) && (page_d == StDodge) &&
        (key_c >= KeyUp) && (key_c <= KeyRight)) begin
      pinstr_d = key_c;
    end
    is_move_d      = (pinstr_d != KeyIdle);
    page_changed_d = (page_d != page_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q         <= StNull;
      page_changed_q <= 1'b0;
      menu_sel_q     <= '0;
      action_sel_q   <= '0;
      action_pick_q  <= 1'b0;
      timer_q        <= '0;
      strike_valid_q <= 1'b0;
      strike_pos_q   <= '0;
      pinstr_q       <= KeyIdle;
      is_move_q      <= 1'b0;
      key_prev_q     <= KeyIdle;
    end else begin
      page_q         <= page_d;
      page_changed_q <= page_changed_d;
      menu_sel_q     <= menu_sel_d;
      action_sel_q   <= action_sel_d;
      action_pick_q  <= action_pick_d;
      timer_q        <= timer_d;
      strike_valid_q <= strike_valid_d;
      strike_pos_q   <= strike_pos_d;
      pinstr_q       <= pinstr_d;
      is_move_q      <= is_move_d;
      key_prev_q     <= key_c;
    end
  end

  assign page_o               = page_q;
  assign page_changed_o       = page_changed_q;
  assign menu_sel_o           = menu_sel_q;
  assign action_sel_o         = action_sel_q;
  assign action_pick_o        = action_pick_q;
  assign timer_o              = timer_q;
  assign strike_valid_o       = strike_valid_q;
  assign strike_pos_o         = strike_pos_q;
  assign player_instruction_o = pinstr_q;
  assign is_move_o            = is_move_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: expected values are queued as stimulus is driven
// and popped when the registered outputs are sampled 1 time unit after clk.
module tb_game_flow_fsm;

  localparam logic [3:0] PgNull = 4'b0000, PgMenu = 4'b0001, PgGameover = 4'b0010;
  localparam logic [3:0] PgStart = 4'b1000, PgDodge = 4'b1001, PgAttack = 4'b1010;
  localparam logic [3:0] PgAction = 4'b1011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  keyboard;
  logic        setup_done, is_death;
  logic [3:0]  page;
  logic        page_changed;
  logic [1:0]  menu_sel, action_sel;
  logic        action_pick;
  logic [15:0] timer;
  logic        strike_valid;
  logic [15:0] strike_pos;
  logic [3:0]  player_instruction;
  logic        is_move;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  game_flow_fsm dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .keyboard_i           (keyboard),
    .setup_done_i         (setup_done),
    .is_death_i           (is_death),
    .page_o               (page),
    .page_changed_o       (page_changed),
    .menu_sel_o           (menu_sel),
    .action_sel_o         (action_sel),
    .action_pick_o        (action_pick),
    .timer_o              (timer),
    .strike_valid_o       (strike_valid),
    .strike_pos_o         (strike_pos),
    .player_instruction_o (player_instruction),
    .is_move_o            (is_move)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; keyboard = 4'd0; setup_done = 1'b0; is_death = 1'b0;
    repeat (3) tick();
    exp_q.push_back(32'(PgNull)); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL reset_page: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL reset_timer: got %0d want %0d", timer, e); end
    e = exp_q.pop_front(); checks++;
    if (32'({menu_sel, action_sel, is_move, strike_valid, action_pick}) !== e) begin
      errors++; $display("FAIL reset_misc: got %0h want %0h",
                         {menu_sel, action_sel, is_move, strike_valid, action_pick}, e);
    end
    rst_n = 1'b1;
    exp_q.push_back(32'(PgMenu)); exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL null_to_menu: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(page_changed) !== e) begin
      errors++; $display("FAIL first_page_changed: got %0d want %0d", page_changed, e);
    end
    exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(page_changed) !== e) begin
      errors++; $display("FAIL page_changed_one_cycle: got %0d want %0d", page_changed, e);
    end
  endtask

  task automatic test_menu();
    keyboard = 4'd1;  // UP wraps 0 -> 2
    exp_q.push_back(32'd2);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(menu_sel) !== e) begin errors++; $display("FAIL menu_up_wrap: got %0d want %0d", menu_sel, e); end
    keyboard = 4'd0; tick();
    keyboard = 4'd3;  // DOWN held: exactly one event, 2 -> 0
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(32'd0);
      tick();
      e = exp_q.pop_front(); checks++;
      if (32'(menu_sel) !== e) begin
        errors++; $display("FAIL menu_down_held[%0d]: got %0d want %0d", i, menu_sel, e);
      end
    end
    keyboard = 4'd0; tick();
    keyboard = 4'd3; tick(); keyboard = 4'd0; tick();  // menu_sel = 1
    keyboard = 4'd5;
    exp_q.push_back(32'(PgMenu)); exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL menu_enter_nonzero: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(menu_sel) !== e) begin errors++; $display("FAIL menu_sel_kept: got %0d want %0d", menu_sel, e); end
    keyboard = 4'd0; tick();
    keyboard = 4'd1; tick(); keyboard = 4'd0; tick();  // back to 0
    keyboard = 4'd5;
    exp_q.push_back(32'(PgStart));
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL menu_to_start: got %0h want %0h", page, e); end
    keyboard = 4'd0; tick();
    setup_done = 1'b1;
    exp_q.push_back(32'(PgAction)); exp_q.push_back(32'd0);
    tick();
    setup_done = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL start_to_action: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(action_sel) !== e) begin errors++; $display("FAIL action_sel_init: got %0d want %0d", action_sel, e); end
  endtask

  task automatic test_action_pick();
    keyboard = 4'd4; tick(); keyboard = 4'd0; tick();
    keyboard = 4'd4; tick(); keyboard = 4'd0; tick();
    keyboard = 4'd5;
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'(PgDodge));
    exp_q.push_back(32'd999);
    tick();
    keyboard = 4'd0;
    e = exp_q.pop_front(); checks++;
    if (32'(action_pick) !== e) begin errors++; $display("FAIL action_pick_pulse: got %0d want %0d", action_pick, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(action_sel) !== e) begin errors++; $display("FAIL action_sel_pick: got %0d want %0d", action_sel, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL action_to_dodge: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL dodge_timer_load: got %0d want %0d", timer, e); end
    exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(action_pick) !== e) begin errors++; $display("FAIL action_pick_clear: got %0d want %0d", action_pick, e); end
    repeat (998) tick();
    exp_q.push_back(32'd0); exp_q.push_back(32'(PgDodge));
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL dodge_timer_zero: got %0d want %0d", timer, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL dodge_at_zero: got %0h want %0h", page, e); end
    exp_q.push_back(32'(PgAction)); exp_q.push_back(32'd2);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL dodge_to_action: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(action_sel) !== e) begin errors++; $display("FAIL action_sel_kept: got %0d want %0d", action_sel, e); end
  endtask

  task automatic test_attack_hit_and_motion();
    int n;
    keyboard = 4'd2; tick(); keyboard = 4'd0; tick();
    keyboard = 4'd2; tick(); keyboard = 4'd0; tick();
    keyboard = 4'd5;
    exp_q.push_back(32'(PgAttack)); exp_q.push_back(32'd499);
    tick();
    keyboard = 4'd0;
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL action_to_attack: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL attack_timer_load: got %0d want %0d", timer, e); end
    repeat (199) tick();
    keyboard = 4'd5;
    exp_q.push_back(32'd1); exp_q.push_back(32'd300); exp_q.push_back(32'(PgDodge));
    exp_q.push_back(32'd999);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(strike_valid) !== e) begin errors++; $display("FAIL strike_valid_hit: got %0d want %0d", strike_valid, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(strike_pos) !== e) begin errors++; $display("FAIL strike_pos_hit: got %0d want %0d", strike_pos, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL attack_to_dodge: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL hit_dodge_load: got %0d want %0d", timer, e); end
    keyboard = 4'd2;
    exp_q.push_back(32'd0); exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(strike_valid) !== e) begin errors++; $display("FAIL strike_valid_clear: got %0d want %0d", strike_valid, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(player_instruction) !== e) begin
      errors++; $display("FAIL move_left: got %0d want %0d", player_instruction, e);
    end
    e = exp_q.pop_front(); checks++;
    if (32'(is_move) !== e) begin errors++; $display("FAIL is_move_left: got %0d want %0d", is_move, e); end
    keyboard = 4'd7;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(player_instruction) !== e) begin
      errors++; $display("FAIL move_code7: got %0d want %0d", player_instruction, e);
    end
    e = exp_q.pop_front(); checks++;
    if (32'(is_move) !== e) begin errors++; $display("FAIL is_move_code7: got %0d want %0d", is_move, e); end
    keyboard = 4'd4;
    n = 0;
    while (page == PgDodge && n < 1100) begin tick(); n++; end
    exp_q.push_back(32'(PgAction)); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL hold_dodge_exit: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(player_instruction) !== e) begin
      errors++; $display("FAIL move_idle_on_exit: got %0d want %0d", player_instruction, e);
    end
    e = exp_q.pop_front(); checks++;
    if (32'(is_move) !== e) begin errors++; $display("FAIL is_move_on_exit: got %0d want %0d", is_move, e); end
    keyboard = 4'd0; tick();
  endtask

  task automatic test_attack_miss();
    int n;
    keyboard = 4'd5; tick(); keyboard = 4'd0;
    n = 0;
    while (page == PgAttack && n < 600) begin tick(); n++; end
    exp_q.push_back(32'd500); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'(PgDodge));
    e = exp_q.pop_front(); checks++;
    if (32'(n) !== e) begin errors++; $display("FAIL attack_window_len: got %0d want %0d", n, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(strike_valid) !== e) begin errors++; $display("FAIL strike_valid_miss: got %0d want %0d", strike_valid, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(strike_pos) !== e) begin errors++; $display("FAIL strike_pos_miss: got %0d want %0d", strike_pos, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL miss_to_dodge: got %0h want %0h", page, e); end
  endtask

  task automatic test_death();
    int n;
    n = 0;
    while (page != PgAction && n < 1100) begin tick(); n++; end
    keyboard = 4'd4; tick(); keyboard = 4'd0; tick();  // action_sel = 1
    keyboard = 4'd5; tick(); keyboard = 4'd0;
    n = 0;
    while (timer != 16'd0 && n < 1100) begin tick(); n++; end
    is_death = 1'b1;
    exp_q.push_back(32'(PgGameover)); exp_q.push_back(32'd0);
    tick();
    is_death = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL death_beats_expiry: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL gameover_timer: got %0d want %0d", timer, e); end
    keyboard = 4'd5;
    exp_q.push_back(32'(PgMenu)); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    tick();
    keyboard = 4'd0;
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL gameover_to_menu: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(menu_sel) !== e) begin errors++; $display("FAIL gameover_menu_sel: got %0d want %0d", menu_sel, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(action_sel) !== e) begin errors++; $display("FAIL gameover_action_sel: got %0d want %0d", action_sel, e); end
    tick();
  endtask

  task automatic test_reset_mid_attack();
    keyboard = 4'd5; tick(); keyboard = 4'd0; tick();
    setup_done = 1'b1; tick(); setup_done = 1'b0;
    keyboard = 4'd5; tick(); keyboard = 4'd0;
    repeat (5) tick();
    exp_q.push_back(32'(PgAttack));
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL reached_attack: got %0h want %0h", page, e); end
    rst_n = 1'b0;
    #2;
    exp_q.push_back(32'(PgNull)); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL async_reset_page: got %0h want %0h", page, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(timer) !== e) begin errors++; $display("FAIL async_reset_timer: got %0d want %0d", timer, e); end
    e = exp_q.pop_front(); checks++;
    if (32'({strike_valid, page_changed, strike_pos}) !== e) begin
      errors++; $display("FAIL async_reset_strike: got %0h want %0h",
                         {strike_valid, page_changed, strike_pos}, e);
    end
    repeat (2) begin
      exp_q.push_back(32'd0);
      tick();
      e = exp_q.pop_front(); checks++;
      if (32'(strike_valid) !== e) begin
        errors++; $display("FAIL no_strike_in_reset: got %0d want %0d", strike_valid, e);
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(32'(PgMenu));
    tick();
    e = exp_q.pop_front(); checks++;
    if (32'(page) !== e) begin errors++; $display("FAIL restart_menu: got %0h want %0h", page, e); end
  endtask

  initial begin
    test_reset();
    test_menu();
    test_action_pick();
    test_attack_hit_and_motion();
    test_attack_miss();
    test_death();
    test_reset_mid_attack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
- Registered, parametrised page/turn controller for the game. Successor to the unregistered page-decode stub.
- Owns the page state (MENU/START/ACTION/ATTACK/DODGE/GAMEOVER) and the menu and action cursors.
- Owns the ATTACK and DODGE turn timers and per-key press detection.
- Drives the player-motion command to the sprite/bullet logic and strike results to the damage logic.

Parameters:
- MENU_ITEMS, 3, number of menu entries; entry 0 = start game. Must be ≤ 2^SEL_W.
- ACTION_ITEMS, 4, number of action entries; entry 0 = FIGHT. Must be ≤ 2^SEL_W.
- SEL_W, 2, cursor width.
- TIMER_W, 16, turn timer width.
- ATTACK_CYCLES, 500, length of the ATTACK window in clocks. Range 1..2^TIMER_W.
- DODGE_CYCLES, 1000, length of the DODGE turn in clocks. Range 1..2^TIMER_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- keyboard  in  4  key code: IDLE=0, UP=1, LEFT=2, DOWN=3, RIGHT=4, ENTER=5; codes 6-15 are treated as IDLE.
- setup_done  in  1  game setting finished; level input.
- is_death  in  1  player HP reached zero; level input.
- page  out  4  current page: NULL=0000, MENU=0001, GAMEOVER=0010, START=1000, DODGE=1001, ATTACK=1010, ACTION=1011.
- page_changed  out  1  one-cycle pulse in the first cycle of a new page.
- menu_sel  out  SEL_W  menu cursor.
- action_sel  out  SEL_W  action cursor.
- action_pick  out  1  one-cycle pulse when a non-FIGHT action is confirmed; action_sel is valid in that cycle.
- timer  out  TIMER_W  remaining turn cycles.
- strike_valid  out  1  one-cycle pulse marking the end of an ATTACK.
- strike_pos  out  TIMER_W  timer value at the ENTER press; 0 = miss.
- player_instruction  out  4  held direction code during DODGE, IDLE otherwise.
- is_move  out  1  high when player_instruction ≠ IDLE.

Behaviour:
- Reset (asynchronous, active-low), all outputs and internal state:
  - page = NULL; menu_sel = 0; action_sel = 0; timer = 0; strike_pos = 0.
  - All pulses = 0; player_instruction = IDLE; is_move = 0; key_prev = IDLE.
- Outputs are registered; pulses are high for exactly one cycle.
- Press event: keyboard ≠ IDLE and key_prev = IDLE.
  - key_prev registers keyboard every cycle.
  - A held key produces exactly one event.
  - A direct change from one non-IDLE code to another produces no event.
- Page transitions are evaluated once per clk. is_death has top priority in ACTION, ATTACK and DODGE.
- NULL:
  - Goes to MENU on the first clk after rst_n deasserts.
- MENU:
  - UP event: menu_sel − 1, wrapping 0 → MENU_ITEMS−1.
  - DOWN event: menu_sel + 1, wrapping MENU_ITEMS−1 → 0.
  - ENTER event with menu_sel = 0: go to START.
  - ENTER event with menu_sel ≠ 0: stay in MENU; no state change.
- START:
  - Stays until setup_done = 1, then goes to ACTION with action_sel = 0.
- ACTION:
  - LEFT event: action_sel − 1 with wrap over ACTION_ITEMS.
  - RIGHT event: action_sel + 1 with wrap over ACTION_ITEMS.
  - ENTER event with action_sel = 0: go to ATTACK; timer loads ATTACK_CYCLES−1.
  - ENTER event with action_sel ≠ 0: pulse action_pick; go to DODGE; timer loads DODGE_CYCLES−1.
- ATTACK:
  - timer decrements each cycle.
  - ENTER event: strike_valid = 1, strike_pos = current timer; go to DODGE with timer = DODGE_CYCLES−1.
  - Timer at 0 with no ENTER: strike_valid = 1, strike_pos = 0; go to DODGE.
  - ENTER and timer = 0 in the same cycle: treated as a miss (strike_pos = 0).
- DODGE:
  - player_instruction = keyboard when the code is UP/LEFT/DOWN/RIGHT (level, not event); otherwise IDLE. One-cycle latency.
  - timer decrements each cycle.
  - Timer at 0: go to ACTION; action_sel is kept.
  - On leaving DODGE, player_instruction = IDLE and is_move = 0 in the same cycle page changes.
- GAMEOVER:
  - Entered from ACTION, ATTACK or DODGE when is_death = 1. is_death beats ENTER and timer expiry in the same cycle.
  - timer is cleared on entry.
  - ENTER event: go to MENU with menu_sel = 0 and action_sel = 0.
- timer holds its value in pages with no running turn.
- page_changed = 1 whenever the registered page differs from its previous-cycle value, including NULL → MENU.
- rst_n asserted mid-turn: immediate return to reset values; no strike_valid pulse is emitted.

Test Plan:
- Release reset, keyboard = 0 → page goes 0000 → 0001 on the first clk; page_changed pulses once; menu_sel = 0.
- MENU, MENU_ITEMS = 3: UP event → menu_sel = 2; DOWN held 10 cycles → menu_sel = 0 (one event only); ENTER → page = 1000; setup_done = 1 → page = 1011.
- ACTION: RIGHT, RIGHT, ENTER → action_pick pulse with action_sel = 2; page = 1001; timer = 999, reaching 0 after 999 cycles, then page = 1011.
- ACTION, ENTER on FIGHT → ATTACK with timer = 499; ENTER when timer = 300 → strike_valid with strike_pos = 300; page = 1001. Repeat with no press → strike_pos = 0 at expiry.
- DODGE: hold LEFT → player_instruction = 0010 and is_move = 1 one cycle later. Change to code 7 → IDLE, is_move = 0.
- DODGE with timer = 0 and is_death = 1 in the same cycle → page = 0010. ENTER → page = 0001, menu_sel = 0. Assert rst_n low mid-ATTACK → all outputs at reset values immediately.
